// File: rtl/ir_key_ctrl_pkg.sv
// Shared types for the IR key-event sequencer: event type codes, FSM states
// and the event word layout.
package ir_key_ctrl_pkg;

    localparam int unsigned EVT_W = 10;
    localparam int unsigned TMR_W = 24;

    typedef enum logic [1:0] {
        EVT_NONE    = 2'b00,
        EVT_PRESS   = 2'b01,
        EVT_REPEAT  = 2'b10,
        EVT_RELEASE = 2'b11
    } evt_type_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD_DLY,
        ST_HOLD_RPT,
        ST_PRESS_PEND
    } key_state_e;

    // Event word: {type[1:0], cmd[7:0]}
    function automatic logic [EVT_W-1:0] make_evt(input evt_type_e kind, input logic [7:0] cmd);
        return {kind, cmd};
    endfunction

endpackage

// File: rtl/ir_key_ctrl_evt_fifo.sv
// First-word-fall-through event FIFO. head shows the oldest entry (0 when
// empty); a push into a full FIFO without a simultaneous pop is dropped and
// flagged on drop.
module ir_evt_fifo
    import ir_key_ctrl_pkg::*;
#(
    parameter int unsigned AW = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [EVT_W-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic             drop,
    output logic [EVT_W-1:0] head
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [EVT_W-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = pop && !empty;
    // A pop on the same edge frees the slot, so push into full is still legal.
    assign push_ok = push && (!full || pop_ok);
    assign drop    = push && full && !pop_ok;
    assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents are masked by empty so no reset is needed
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/ir_key_ctrl.sv
// Key-event sequencer: turns the IR receiver's held code and per-frame ack
// into PRESS / REPEAT / RELEASE events with locally generated repeat timing,
// queued in a small FWFT FIFO for firmware.
module ir_key_ctrl
    import ir_key_ctrl_pkg::*;
#(
    parameter logic [7:0]  REMOTE_ADDR    = 8'h3E,
    parameter bit          ADDR_FILTER_EN = 1'b1,
    parameter int unsigned RPT_DELAY      = 13500000,
    parameter int unsigned RPT_RATE       = 2700000,
    parameter int unsigned FIFO_AW        = 2
) (
    input  logic        clk27,
    input  logic        reset_n,
    input  logic [15:0] ir_code,
    input  logic        ir_code_ack,
    input  logic        evt_rd,
    input  logic        ovf_clr,
    output logic        evt_valid,
    output logic [9:0]  evt_data,
    output logic        evt_overflow,
    output logic        key_held,
    output logic [7:0]  held_cmd
);

    localparam logic [TMR_W-1:0] DLY_LAST  = TMR_W'(RPT_DELAY - 1);
    localparam logic [TMR_W-1:0] RATE_LAST = TMR_W'(RPT_RATE - 1);

    key_state_e       state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [7:0]       held_q, held_d;
    logic [7:0]       pend_q, pend_d;
    logic             key_held_q;
    logic             ovf_q;

    logic             addr_ok;
    logic             accept;
    logic             rel;
    logic             push;
    logic [EVT_W-1:0] push_data;

    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_drop;
    logic [EVT_W-1:0] fifo_head;

    assign addr_ok = !ADDR_FILTER_EN || (ir_code[15:8] == REMOTE_ADDR);
    assign accept  = ir_code_ack && (ir_code != '0) && addr_ok;
    assign rel     = (ir_code == '0);

    // Next-state, timer and event generation; at most one push per cycle
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q + 1'b1;
        held_d    = held_q;
        pend_d    = pend_q;
        push      = 1'b0;
        push_data = '0;
        unique case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (accept) begin
                    held_d    = ir_code[7:0];
                    push      = 1'b1;
                    push_data = make_evt(EVT_PRESS, ir_code[7:0]);
                    state_d   = ST_HOLD_DLY;
                end
            end
            ST_HOLD_DLY, ST_HOLD_RPT: begin
                if (rel) begin
                    push      = 1'b1;
                    push_data = make_evt(EVT_RELEASE, held_q);
                    held_d    = '0;
                    timer_d   = '0;
                    state_d   = ST_IDLE;
                end else if (accept && (ir_code[7:0] != held_q)) begin
                    // Release the old key now, press the new one next cycle
                    push      = 1'b1;
                    push_data = make_evt(EVT_RELEASE, held_q);
                    pend_d    = ir_code[7:0];
                    timer_d   = '0;
                    state_d   = ST_PRESS_PEND;
                end else if ((state_q == ST_HOLD_DLY) && (timer_q == DLY_LAST)) begin
                    push      = 1'b1;
                    push_data = make_evt(EVT_REPEAT, held_q);
                    timer_d   = '0;
                    state_d   = ST_HOLD_RPT;
                end else if ((state_q == ST_HOLD_RPT) && (timer_q == RATE_LAST)) begin
                    push      = 1'b1;
                    push_data = make_evt(EVT_REPEAT, held_q);
                    timer_d   = '0;
                end
            end
            ST_PRESS_PEND: begin
                // A release seen here is handled by HOLD_DLY on the next cycle
                held_d    = pend_q;
                push      = 1'b1;
                push_data = make_evt(EVT_PRESS, pend_q);
                timer_d   = '0;
                state_d   = ST_HOLD_DLY;
            end
            default: begin
                timer_d = '0;
                held_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state, timer and latched key registers
    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            held_q     <= '0;
            pend_q     <= '0;
            key_held_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            held_q     <= held_d;
            pend_q     <= pend_d;
            key_held_q <= (state_d != ST_IDLE);
        end
    end

    // Sticky overflow flag; a drop in the same cycle as a clear wins
    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
        end else if (fifo_drop && fifo_full) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    ir_evt_fifo #(
        .AW (FIFO_AW)
    ) u_fifo (
        .clk       (clk27),
        .rst_n     (reset_n),
        .push      (push),
        .push_data (push_data),
        .pop       (evt_rd),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .drop      (fifo_drop),
        .head      (fifo_head)
    );

    assign evt_valid    = !fifo_empty;
    assign evt_data     = fifo_head;
    assign evt_overflow = ovf_q;
    assign key_held     = key_held_q;
    assign held_cmd     = held_q;

endmodule

// File: tb/tb_ir_key_ctrl.sv
// Bench for ir_key_ctrl: table of single frames against a filtering and a
// non-filtering instance, plus timed sequences for repeat cadence, key
// change, FIFO overflow and reset; events are checked through a scoreboard.
module tb_ir_key_ctrl;

    localparam logic [1:0] T_PRESS   = 2'b01;
    localparam logic [1:0] T_REPEAT  = 2'b10;
    localparam logic [1:0] T_RELEASE = 2'b11;

    logic        clk27 = 1'b0;
    logic        reset_n;
    logic [15:0] ir_code;
    logic        ack;
    logic        ack_nf;
    logic        rd;
    logic        rd_nf;
    logic        ovf_clr;

    logic        evt_valid, nf_valid;
    logic [9:0]  evt_data, nf_data;
    logic        evt_overflow, nf_overflow;
    logic        key_held, nf_key_held;
    logic [7:0]  held_cmd, nf_held_cmd;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [9:0] data;
        int         dly;   // cycles since previous popped event, -1 = unchecked
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [15:0] code;
        logic        held;
        logic [7:0]  cmd;
        logic        nf_held;
        logic [7:0]  nf_cmd;
    } vec_t;
    vec_t vecs[6];

    always #5 clk27 = ~clk27;

    ir_key_ctrl #(
        .REMOTE_ADDR    (8'h3E),
        .ADDR_FILTER_EN (1'b1),
        .RPT_DELAY      (100),
        .RPT_RATE       (20),
        .FIFO_AW        (2)
    ) dut (
        .clk27        (clk27),
        .reset_n      (reset_n),
        .ir_code      (ir_code),
        .ir_code_ack  (ack),
        .evt_rd       (rd),
        .ovf_clr      (ovf_clr),
        .evt_valid    (evt_valid),
        .evt_data     (evt_data),
        .evt_overflow (evt_overflow),
        .key_held     (key_held),
        .held_cmd     (held_cmd)
    );

    ir_key_ctrl #(
        .REMOTE_ADDR    (8'h3E),
        .ADDR_FILTER_EN (1'b0),
        .RPT_DELAY      (100),
        .RPT_RATE       (20),
        .FIFO_AW        (2)
    ) dut_nf (
        .clk27        (clk27),
        .reset_n      (reset_n),
        .ir_code      (ir_code),
        .ir_code_ack  (ack_nf),
        .evt_rd       (rd_nf),
        .ovf_clr      (1'b0),
        .evt_valid    (nf_valid),
        .evt_data     (nf_data),
        .evt_overflow (nf_overflow),
        .key_held     (nf_key_held),
        .held_cmd     (nf_held_cmd)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] kind, input logic [7:0] cmd, input int dly);
        exp_t e;
        e.data = {kind, cmd};
        e.dly  = dly;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk27);
        repeat (2) @(negedge clk27);
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Press 3E1C, hold 250 cycles (optionally re-acking), then release
    task automatic hold_scenario(input int ack_period);
        @(negedge clk27);
        ir_code = 16'h3E1C;
        ack     = 1'b1;
        push_exp(T_PRESS, 8'h1C, -1);
        push_exp(T_REPEAT, 8'h1C, 100);
        for (int i = 0; i < 7; i++) push_exp(T_REPEAT, 8'h1C, 20);
        push_exp(T_RELEASE, 8'h1C, 10);
        for (int k = 1; k < 250; k++) begin
            @(negedge clk27);
            ack = (ack_period != 0) && (k % ack_period == 0);
        end
        @(negedge clk27);
        ack     = 1'b0;
        ir_code = 16'h0000;
    endtask

    // Scoreboard monitor: compares each popped head with the next expectation
    initial begin : monitor
        exp_t e;
        int   cyc  = 0;
        int   last = 0;
        forever begin
            @(negedge clk27);
            #2;
            cyc++;
            if (reset_n && evt_valid && rd) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL spurious_evt: got 0x%0h expected no event", evt_data);
                end else begin
                    e = exp_q.pop_front();
                    check("evt_data", evt_data, e.data);
                    if (e.dly >= 0) check("evt_gap", cyc - last, e.dly);
                end
                last = cyc;
            end
        end
    end

    initial begin : stim
        vecs[0] = '{16'h3E1C, 1'b1, 8'h1C, 1'b1, 8'h1C};
        vecs[1] = '{16'h4A1C, 1'b0, 8'h00, 1'b1, 8'h1C};
        vecs[2] = '{16'h0000, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[3] = '{16'h3E00, 1'b1, 8'h00, 1'b1, 8'h00};
        vecs[4] = '{16'h003E, 1'b0, 8'h00, 1'b1, 8'h3E};
        vecs[5] = '{16'h3EFF, 1'b1, 8'hFF, 1'b1, 8'hFF};

        reset_n = 1'b0;
        ir_code = '0;
        ack     = 1'b0;
        ack_nf  = 1'b0;
        rd      = 1'b1;
        rd_nf   = 1'b1;
        ovf_clr = 1'b0;

        repeat (3) @(negedge clk27);
        check("rst_valid", evt_valid, 1'b0);
        check("rst_data", evt_data, 10'h000);
        check("rst_ovf", evt_overflow, 1'b0);
        check("rst_key_held", key_held, 1'b0);
        check("rst_held_cmd", held_cmd, 8'h00);
        reset_n = 1'b1;
        repeat (2) @(negedge clk27);

        // Single-frame table: address filter on vs. off
        for (int i = 0; i < 6; i++) begin
            @(negedge clk27);
            ir_code = vecs[i].code;
            ack     = 1'b1;
            ack_nf  = 1'b1;
            if (vecs[i].held) push_exp(T_PRESS, vecs[i].cmd, -1);
            @(negedge clk27);
            ack    = 1'b0;
            ack_nf = 1'b0;
            check("tbl_key_held", key_held, vecs[i].held);
            check("tbl_held_cmd", held_cmd, vecs[i].cmd);
            check("tbl_nf_key_held", nf_key_held, vecs[i].nf_held);
            check("tbl_nf_held_cmd", nf_held_cmd, vecs[i].nf_cmd);
            check("tbl_nf_valid", nf_valid, vecs[i].nf_held);
            check("tbl_nf_data", nf_data, vecs[i].nf_held ? {T_PRESS, vecs[i].nf_cmd} : 10'h000);
            ir_code = 16'h0000;
            if (vecs[i].held) push_exp(T_RELEASE, vecs[i].cmd, -1);
            repeat (5) @(negedge clk27);
        end
        drain("tbl_drain");

        // Repeat cadence without and with repeat-frame acks
        hold_scenario(0);
        drain("hold_drain");
        repeat (5) @(negedge clk27);
        hold_scenario(30);
        drain("hold_ack_drain");
        repeat (5) @(negedge clk27);

        // Key change while held
        @(negedge clk27);
        ir_code = 16'h3E1C;
        ack     = 1'b1;
        push_exp(T_PRESS, 8'h1C, -1);
        push_exp(T_RELEASE, 8'h1C, 50);
        push_exp(T_PRESS, 8'h05, 1);
        push_exp(T_RELEASE, 8'h05, 1);
        for (int k = 1; k < 50; k++) begin
            @(negedge clk27);
            ack = 1'b0;
        end
        @(negedge clk27);
        ir_code = 16'h3E05;
        ack     = 1'b1;
        @(negedge clk27);
        ack = 1'b0;
        check("chg_pend_held", key_held, 1'b1);
        check("chg_pend_cmd", held_cmd, 8'h1C);
        @(negedge clk27);
        check("chg_held_cmd", held_cmd, 8'h05);
        ir_code = 16'h0000;
        drain("chg_drain");
        repeat (5) @(negedge clk27);

        // Overflow: five events with no pops, then push+pop while full
        @(negedge clk27);
        rd      = 1'b0;
        ir_code = 16'h3E01;
        ack     = 1'b1;
        push_exp(T_PRESS, 8'h01, -1);
        push_exp(T_RELEASE, 8'h01, -1);
        push_exp(T_PRESS, 8'h02, -1);
        push_exp(T_RELEASE, 8'h02, -1);
        @(negedge clk27);
        ack = 1'b0;
        @(negedge clk27);
        ir_code = 16'h3E02;
        ack     = 1'b1;
        @(negedge clk27);
        ack = 1'b0;
        @(negedge clk27);
        @(negedge clk27);
        ir_code = 16'h3E03;
        ack     = 1'b1;
        @(negedge clk27);
        ack = 1'b0;
        @(negedge clk27);
        check("ovf_set", evt_overflow, 1'b1);
        check("ovf_valid", evt_valid, 1'b1);
        check("ovf_head", evt_data, {T_PRESS, 8'h01});
        @(negedge clk27);
        check("ovf_sticky", evt_overflow, 1'b1);
        ovf_clr = 1'b1;
        @(negedge clk27);
        ovf_clr = 1'b0;
        check("ovf_cleared", evt_overflow, 1'b0);
        @(negedge clk27);
        ir_code = 16'h3E04;
        ack     = 1'b1;
        rd      = 1'b1;
        push_exp(T_RELEASE, 8'h03, -1);
        push_exp(T_PRESS, 8'h04, -1);
        @(negedge clk27);
        ack = 1'b0;
        check("ovf_pushpop0", evt_overflow, 1'b0);
        @(negedge clk27);
        check("ovf_pushpop1", evt_overflow, 1'b0);
        repeat (6) @(negedge clk27);
        ir_code = 16'h0000;
        push_exp(T_RELEASE, 8'h04, -1);
        drain("ovf_drain");
        repeat (5) @(negedge clk27);

        // Reset while repeating with two queued events
        @(negedge clk27);
        rd      = 1'b0;
        ir_code = 16'h3E1C;
        ack     = 1'b1;
        for (int k = 1; k < 106; k++) begin
            @(negedge clk27);
            ack = 1'b0;
        end
        check("prerst_key_held", key_held, 1'b1);
        check("prerst_valid", evt_valid, 1'b1);
        check("prerst_head", evt_data, {T_PRESS, 8'h1C});
        reset_n = 1'b0;
        ir_code = 16'h0000;
        #1;
        check("midrst_valid", evt_valid, 1'b0);
        check("midrst_data", evt_data, 10'h000);
        check("midrst_ovf", evt_overflow, 1'b0);
        check("midrst_key_held", key_held, 1'b0);
        check("midrst_held_cmd", held_cmd, 8'h00);
        repeat (2) @(negedge clk27);
        reset_n = 1'b1;
        rd      = 1'b1;
        repeat (20) @(negedge clk27);
        check("postrst_valid", evt_valid, 1'b0);
        check("postrst_key_held", key_held, 1'b0);
        check("postrst_queue", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
